// File: rtl/maxnet_controller_if.sv
// rtl/maxnet_controller_if.sv - control/status bundle between the MAXNET sequencer, its host and datapath
interface maxnet_controller_if #(
  parameter int ITER_W = 4
);
  logic              start;
  logic              is_finished;
  logic              load_a;
  logic              load_sel;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [ITER_W-1:0] iter_count;

  modport master (
    input  start, is_finished,
    output load_a, load_sel, busy, done, timeout, iter_count
  );

  modport slave (
    output start, is_finished,
    input  load_a, load_sel, busy, done, timeout, iter_count
  );
endinterface

// File: rtl/maxnet_controller.sv
// rtl/maxnet_controller.sv - MAXNET winner-selection sequencer (load, iterate PU, stop on single survivor)
// MAXNET_TIMEOUT_EN enables the MAX_ITER limit and timeout flag; otherwise iter_count saturates.
module maxnet_controller #(
  parameter int PU_LAT   = 2,
  parameter int MAX_ITER = 15,
  parameter int ITER_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  maxnet_controller_if.master  ctl
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [3:0]        WAIT_INIT = 4'(PU_LAT - 1);
  localparam logic [ITER_W-1:0] ITER_SAT  = {ITER_W{1'b1}};
`ifdef MAXNET_TIMEOUT_EN
  localparam logic [ITER_W-1:0] ITER_LIM  = ITER_W'(MAX_ITER);
`endif

  logic [2:0]        state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    iter_d    = iter_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (ctl.start) begin
          state_d   = S_LOAD;
          iter_d    = '0;
          timeout_d = 1'b0;
        end
      end
      S_LOAD: state_d = S_CHECK;
      S_CHECK: begin
        // A single survivor wins over the iteration limit.
        if (ctl.is_finished) begin
          state_d = S_DONE;
        end
`ifdef MAXNET_TIMEOUT_EN
        else if (iter_q == ITER_LIM) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
`endif
        else begin
          state_d = S_WAIT;
          wait_d  = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (wait_q == 4'd0) begin
          state_d = S_UPDATE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_UPDATE: begin
        state_d = S_CHECK;
        if (iter_q != ITER_SAT) begin
          iter_d = iter_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wait_q    <= 4'd0;
      iter_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      iter_q    <= iter_d;
      timeout_q <= timeout_d;
    end
  end

  assign ctl.load_a     = (state_q == S_LOAD) || (state_q == S_UPDATE);
  assign ctl.load_sel   = (state_q == S_LOAD);
  assign ctl.busy       = (state_q != S_IDLE);
  assign ctl.done       = (state_q == S_DONE);
  assign ctl.timeout    = timeout_q;
  assign ctl.iter_count = iter_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// tb/tb_maxnet_controller.sv - scoreboard bench for maxnet_controller (MAXNET_TIMEOUT_EN aware)
module tb_maxnet_controller;

  localparam int PU_LAT   = 2;
  localparam int MAX_ITER = 15;
  localparam int ITER_W   = 4;

  typedef struct {
    int upd;
    int iter;
    int tmo;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  maxnet_controller_if #(.ITER_W(ITER_W)) ctl ();

  maxnet_controller #(
    .PU_LAT   (PU_LAT),
    .MAX_ITER (MAX_ITER),
    .ITER_W   (ITER_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ctl (ctl)
  );

  exp_t exp_q[$];
  int   checks     = 0;
  int   errors     = 0;
  int   cyc        = 0;
  int   fin_after  = -1;
  int   upd_cnt    = 0;
  int   last_upd   = -1;
  int   load_cyc   = 0;
  int   load_cnt   = 0;
  int   done_cnt   = 0;
  bit   run_active = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-in: one neuron survives once fin_after UPDATE loads have happened.
  assign ctl.is_finished = run_active && (fin_after >= 0) && (upd_cnt >= fin_after);

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: observes LOAD/UPDATE/done and scores each finished run against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        run_active = 1'b0;
        upd_cnt    = 0;
        last_upd   = -1;
      end else begin
        if (ctl.load_a && ctl.load_sel) begin
          chk("extra_load", int'(run_active), 0);
          chk("load_iter_clr", int'(ctl.iter_count), 0);
          chk("load_tmo_clr", int'(ctl.timeout), 0);
          run_active = 1'b1;
          load_cyc   = cyc;
          upd_cnt    = 0;
          last_upd   = -1;
          load_cnt++;
        end
        if (ctl.load_a && !ctl.load_sel) begin
          if (last_upd >= 0) chk("upd_spacing", cyc - last_upd, PU_LAT + 2);
          upd_cnt++;
          last_upd = cyc;
        end
        if (ctl.done) begin
          done_cnt++;
          run_active = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no done");
          end else begin
            e = exp_q.pop_front();
            chk("updates", upd_cnt, e.upd);
            chk("iter_count", int'(ctl.iter_count), e.iter);
            chk("timeout", int'(ctl.timeout), e.tmo);
            chk("done_latency", cyc - load_cyc, e.lat);
          end
        end
      end
    end
  end

  task automatic run(input int fin, input bit expect_done, input exp_t e, input int budget);
    int d0;
    int n;
    d0        = done_cnt;
    n         = 0;
    fin_after = fin;
    if (expect_done) exp_q.push_back(e);
    @(posedge clk); #1 ctl.start = 1'b1;
    @(posedge clk); #1 ctl.start = 1'b0;
    if (expect_done) begin
      while (done_cnt == d0 && n < budget) begin
        @(posedge clk); #1;
        n++;
      end
      chk("done_seen", done_cnt - d0, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int lc;
    int d0;
    int n;
    ctl.start = 1'b0;
    rst       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(ctl.busy), 0);
    chk("rst_load_a", int'(ctl.load_a), 0);
    chk("rst_load_sel", int'(ctl.load_sel), 0);
    chk("rst_done", int'(ctl.done), 0);
    chk("rst_timeout", int'(ctl.timeout), 0);
    chk("rst_iter", int'(ctl.iter_count), 0);
    rst = 1'b1;

    run(0, 1'b1, '{0, 0, 0, 2}, 20);
    run(3, 1'b1, '{3, 3, 0, 14}, 50);

`ifdef MAXNET_TIMEOUT_EN
    run(-1, 1'b1, '{15, 15, 1, 62}, 100);
    repeat (3) @(posedge clk);
    #1;
    chk("timeout_held", int'(ctl.timeout), 1);
    chk("iter_held", int'(ctl.iter_count), 15);
    chk("idle_busy", int'(ctl.busy), 0);
`else
    run(-1, 1'b0, '{0, 0, 0, 0}, 0);
    repeat (300) @(posedge clk);
    #1;
    chk("no_timeout", int'(ctl.timeout), 0);
    chk("iter_sat", int'(ctl.iter_count), 15);
    chk("still_busy", int'(ctl.busy), 1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
`endif

    run(15, 1'b1, '{15, 15, 0, 62}, 100);

    // Start held through CHECK/WAIT/UPDATE must not re-launch; then reset lands mid-WAIT.
    lc        = load_cnt;
    fin_after = -1;
    @(posedge clk); #1 ctl.start = 1'b1;
    repeat (5) @(posedge clk);
    #1 ctl.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_before_rst", int'(ctl.busy), 1);
    chk("iter_before_rst", int'(ctl.iter_count), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_busy", int'(ctl.busy), 0);
    chk("async_load_a", int'(ctl.load_a), 0);
    chk("async_iter", int'(ctl.iter_count), 0);
    chk("no_requeue", load_cnt - lc, 1);

    ctl.start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    fin_after = 0;
    exp_q.push_back('{0, 0, 0, 2});
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("first_edge_load", int'(ctl.load_a && ctl.load_sel), 1);
    ctl.start = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", done_cnt - d0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maxnet_controller.md
MAXNET_CONTROLLER -- requirements
Module: maxnet_controller

Interface
REQ-001 The block SHALL have parameter PU_LAT, default 2, giving the PU pipeline latency in cycles (legal range 1..15).
REQ-002 The block SHALL have parameter MAX_ITER, default 15, giving the iteration limit (legal range 1..2^ITER_W-1).
REQ-003 The block SHALL have parameter ITER_W, default 4, giving the width of the iteration counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: request one winner-selection run; sampled only in IDLE.
REQ-007 The block SHALL have port is_finished, input, 1 bit: datapath flag meaning one neuron remains nonzero; valid the cycle after any load.
REQ-008 The block SHALL have port load_a, output, 1 bit: neuron register load enable to the datapath.
REQ-009 The block SHALL have port load_sel, output, 1 bit: 1 selects memory inputs, 0 selects PU outputs.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when a run ends.
REQ-012 The block SHALL have port timeout, output, 1 bit: the last run hit MAX_ITER without convergence; held until the next accepted start.
REQ-013 The block SHALL have port iter_count, output, ITER_W bits: number of UPDATE loads completed in the current or last run.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, LOAD, CHECK, WAIT, UPDATE and DONE; load_a, load_sel, busy and done SHALL be Moore outputs decoded from the state.
REQ-015 In IDLE, when start=1 at a rising edge, the FSM SHALL go to LOAD, clear iter_count to 0 and clear timeout to 0; start=0 SHALL keep the FSM in IDLE.
REQ-016 In LOAD, load_a=1 and load_sel=1 for exactly one cycle; the next state SHALL be CHECK.
REQ-017 In CHECK (load_a=0), is_finished=1 SHALL go to DONE; otherwise, if iter_count==MAX_ITER, the FSM SHALL go to DONE and set timeout=1; otherwise it SHALL go to WAIT with the wait counter loaded with PU_LAT-1.
REQ-018 When is_finished=1 and iter_count==MAX_ITER in the same CHECK cycle, is_finished SHALL take priority and timeout SHALL stay 0.
REQ-019 In WAIT (load_a=0), the wait counter SHALL decrement each cycle; on the cycle it reads 0, the next state SHALL be UPDATE.
REQ-020 In UPDATE, load_a=1 and load_sel=0 for exactly one cycle; iter_count SHALL increment at that cycle's end edge, and the next state SHALL be CHECK.
REQ-021 Each iteration SHALL take exactly PU_LAT+2 cycles (UPDATE, CHECK, then PU_LAT WAIT cycles).
REQ-022 In DONE, done=1 for one cycle; the next state SHALL be IDLE; iter_count and timeout SHALL hold until the next accepted start.
REQ-023 A start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-024 iter_count SHALL never wrap, because CHECK terminates the run at MAX_ITER.
REQ-025 load_a and load_sel SHALL both be 0 in IDLE, CHECK, WAIT and DONE.

Reset
REQ-026 While rst=0, the FSM SHALL go to IDLE immediately, independent of clk, including mid-run.
REQ-027 While rst=0, load_a, load_sel, busy, done and timeout SHALL be 0, and iter_count and the wait counter SHALL be 0.
REQ-028 After rst is released, the first start SHALL be accepted at the first rising edge where rst=1.

Configuration
REQ-029 With macro MAXNET_TIMEOUT_EN defined, the iteration limit and timeout behaviour of REQ-017/018 SHALL apply.
REQ-030 With MAXNET_TIMEOUT_EN undefined, CHECK SHALL go to WAIT whenever is_finished=0, timeout SHALL be tied to 0, and iter_count SHALL saturate at 2^ITER_W-1 instead of wrapping.

Verification
REQ-031 Reset then start with is_finished=1 held -> LOAD for 1 cycle (load_a=1, load_sel=1), CHECK, done pulse 2 cycles after LOAD, iter_count=0, timeout=0.
REQ-032 PU_LAT=2, is_finished rises after the 3rd UPDATE -> exactly 3 UPDATE pulses spaced 4 cycles apart, done=1, iter_count=3, timeout=0.
REQ-033 MAX_ITER=15, is_finished=0 always, macro defined -> 15 UPDATE pulses, done=1, timeout=1, iter_count=15; the next start clears timeout to 0.
REQ-034 Same stimulus as REQ-033 with the macro undefined -> no done within 300 cycles, iter_count saturates at 15, timeout stays 0.
REQ-035 Start re-asserted during WAIT, then rst=0 pulsed mid-WAIT -> start ignored (no extra LOAD); on reset, busy=0 and load_a=0 immediately, without waiting for clk.
REQ-036 is_finished=1 in the same CHECK as iter_count==MAX_ITER -> done=1, timeout=0.
